// File: rtl/convenc_punct.sv
// convenc_punct: K=7 rate-1/2 convolutional encoder with 802.11a puncturing to 2/3 and 3/4
module convenc_punct #(
    parameter int DWIDTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        coderate,
    input  logic [14:0]       nofbits,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_bit,
    output logic [DWIDTH-1:0] out_sample,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_done
);
    typedef enum logic [1:0] {IDLE, FETCH, ENC, DONE} state_t;
    state_t state, state_nx;
    logic [1:0] rate, phase;
    logic [14:0] nbits, bit_cnt;
    logic [5:0] sr;
    logic [7:0] byte_r;
    logic [2:0] bit_idx;
    logic sub, d, a, b, has_a, has_b, last, code, cnt_end;
    // current data bit, both generator outputs and which of them this beat carries
    always_comb begin
        d = byte_r[bit_idx];
        a = d ^ sr[1] ^ sr[2] ^ sr[4] ^ sr[5];
        b = d ^ sr[0] ^ sr[1] ^ sr[2] ^ sr[5];
        has_a = !(rate == 2'd2 && phase == 2'd2);
        has_b = phase == 2'd0 || phase == 2'd2;
        last = (has_a && has_b) ? sub : 1'b1;
        code = (sub || !has_a) ? b : a;
        cnt_end = bit_cnt + 15'd1 == nbits;
    end
    // state register
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end
    // next state and Moore outputs
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        out_valid = 1'b0;
        busy = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            IDLE: if (start) state_nx = nofbits == 15'd0 ? DONE : FETCH;
            FETCH: begin
                in_ready = 1'b1;
                busy = 1'b1;
                if (in_valid) state_nx = ENC;
            end
            ENC: begin
                out_valid = 1'b1;
                busy = 1'b1;
                if (out_ready && last) state_nx = cnt_end ? DONE : (bit_idx == 3'd7 ? FETCH : ENC);
            end
            DONE: begin
                frame_done = 1'b1;
                state_nx = IDLE;
            end
        endcase
        out_bit = out_valid && code;
        out_sample = !out_valid ? '0 : code ? {1'b0, {(DWIDTH-1){1'b1}}} : {1'b1, {(DWIDTH-2){1'b0}}, 1'b1};
    end
    // frame parameters, byte buffer, encoder memory and puncturing position
    always_ff @(posedge clock) begin
        if (!reset) begin
            rate <= '0;
            nbits <= '0;
            sr <= '0;
            bit_cnt <= '0;
            phase <= '0;
            sub <= 1'b0;
            byte_r <= '0;
            bit_idx <= '0;
        end else begin
            if (state == IDLE && start) begin
                rate <= coderate == 2'd3 ? 2'd0 : coderate;
                nbits <= nofbits;
                sr <= '0;
                bit_cnt <= '0;
                phase <= '0;
                sub <= 1'b0;
            end
            if (state == FETCH && in_valid) begin
                byte_r <= in_byte;
                bit_idx <= '0;
            end
            if (state == ENC && out_ready) begin
                sub <= !last;
                if (last) begin
                    sr <= {sr[4:0], d};
                    bit_cnt <= bit_cnt + 15'd1;
                    phase <= (rate == 2'd0 || phase == rate) ? 2'd0 : phase + 2'd1;
                    bit_idx <= bit_idx + 3'd1;
                end
            end
        end
    end
endmodule
